// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring counter and its receive-side checker.
package ring_pkg;

  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} ring_state_e;

  // rot_right works on a widest-case vector so both counter and checker can share it
  localparam int unsigned MAX_SIZE = 64;
  localparam int unsigned DEF_SIZE = 4;

  function automatic int unsigned pos_width(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  localparam int unsigned POS_W = pos_width(DEF_SIZE);

  // Bit i takes bit i+1 and bit size-1 takes bit 0; x must be zero above size-1.
  function automatic logic [MAX_SIZE-1:0] rot_right(input logic [MAX_SIZE-1:0] x,
                                                    input int unsigned        size);
    logic [MAX_SIZE-1:0] r;
    r          = x >> 1;
    r[size-1]  = x[0];
    return r;
  endfunction

endpackage

// File: rtl/ring_if.sv
// Ring bus plus checker status, as seen by a driver (master) and the checker (slave).
interface ring_if
  import ring_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned ERR_W = 8
);
  localparam int unsigned PW = pos_width(SIZE);

  logic            in_valid;
  logic [SIZE-1:0] ring_in;
  logic            clr_err;
  logic [PW-1:0]   pos;
  logic            pos_valid;
  logic            locked;
  logic            err_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (output in_valid, ring_in, clr_err,
                  input  pos, pos_valid, locked, err_pulse, err_count);
  modport slave  (input  in_valid, ring_in, clr_err,
                  output pos, pos_valid, locked, err_pulse, err_count);
endinterface

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot check (popcount == 1) and OR-reduction binary encoder.
module ring_onehot_decode
  import ring_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0]            ring,
  output logic                       is_onehot,
  output logic [pos_width(SIZE)-1:0] idx
);
  localparam int unsigned PW = pos_width(SIZE);
  localparam int unsigned CW = $clog2(SIZE + 1);

  logic [CW-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < SIZE; i++)
      cnt = cnt + CW'(ring[i]);
  end

  assign is_onehot = (cnt == CW'(1));

  // Index bit b is the OR of every ring bit whose position has bit b set.
  always_comb begin
    idx = '0;
    for (int unsigned b = 0; b < PW; b++)
      for (int unsigned i = 0; i < SIZE; i++)
        if (((i >> b) & 1) != 0)
          idx[b] = idx[b] | ring[i];
  end

endmodule

// File: rtl/ring_checker.sv
// Ring-counter integrity monitor: locks onto a rotate-right one-hot sequence,
// decodes the active position and counts sequence errors seen while locked.
module ring_checker
  import ring_pkg::*;
#(
  parameter int unsigned SIZE     = 4,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  ring_if.slave bus
);
  localparam int unsigned PW = pos_width(SIZE);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);

  ring_state_e      state;
  logic [SIZE-1:0]  last;
  logic [MW-1:0]    match_cnt;
  logic [PW-1:0]    pos_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_count_q;

  logic             is_onehot;
  logic [PW-1:0]    idx;
  logic [SIZE-1:0]  exp_ring;
  logic             hit;
  logic             err_evt;

  ring_onehot_decode #(.SIZE(SIZE)) u_dec (
    .ring      (bus.ring_in),
    .is_onehot (is_onehot),
    .idx       (idx)
  );

  assign exp_ring = SIZE'(rot_right(MAX_SIZE'(last), SIZE));
  assign hit      = is_onehot && (bus.ring_in == exp_ring);
  assign err_evt  = bus.in_valid && (state == LOCKED) && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      last        <= SIZE'(1);
      match_cnt   <= '0;
      pos_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= err_evt;
      if (bus.clr_err)
        err_count_q <= '0;
      else if (err_evt && err_count_q != '1)
        err_count_q <= err_count_q + ERR_W'(1);

      if (bus.in_valid) begin
        unique case (state)
          HUNT: begin
            if (is_onehot) begin
              last      <= bus.ring_in;
              pos_q     <= idx;
              match_cnt <= MW'(1);
              state     <= (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
              locked_q  <= (LOCK_CNT == 1);
            end
          end
          ACQUIRE: begin
            if (hit) begin
              last      <= bus.ring_in;
              pos_q     <= idx;
              match_cnt <= match_cnt + MW'(1);
              if (match_cnt == MW'(LOCK_CNT - 1)) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end
            end else if (is_onehot) begin
              last      <= bus.ring_in;
              pos_q     <= idx;
              match_cnt <= MW'(1);
            end else begin
              state     <= HUNT;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (hit) begin
              last  <= bus.ring_in;
              pos_q <= idx;
            end else if (is_onehot) begin
              // with LOCK_CNT==1 a single good-looking sample is already a lock
              last      <= bus.ring_in;
              pos_q     <= idx;
              match_cnt <= MW'(1);
              if (LOCK_CNT != 1) begin
                state    <= ACQUIRE;
                locked_q <= 1'b0;
              end
            end else begin
              state     <= HUNT;
              locked_q  <= 1'b0;
              match_cnt <= '0;
            end
          end
          default: begin
            state    <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pos       = pos_q;
  assign bus.pos_valid = locked_q;
  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_ring_checker.sv
// Directed bench for ring_checker: SIZE=4, LOCK_CNT=2, plus an ERR_W=2 instance for saturation.
module tb_ring_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ring_if #(.SIZE(4), .ERR_W(8)) bus ();
  ring_if #(.SIZE(4), .ERR_W(2)) bus2 ();

  ring_checker #(.SIZE(4), .LOCK_CNT(2), .ERR_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ring_checker #(.SIZE(4), .LOCK_CNT(2), .ERR_W(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v;
    logic [3:0] r;
    logic       lk;
    logic [1:0] p;
    logic       ep;
    logic [7:0] ec;
  } vec_t;

  task automatic drive(input logic v, input logic [3:0] r);
    bus.in_valid = v;
    bus.ring_in  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic v, input logic [3:0] r, input logic clr);
    bus2.in_valid = v;
    bus2.ring_in  = r;
    bus2.clr_err  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.ring_in = 4'b0000; bus.clr_err = 1'b0;
    bus2.in_valid = 1'b0; bus2.ring_in = 4'b0000; bus2.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
    checks++; if (bus.pos_valid !== 1'b0) begin errors++; $display("FAIL reset_pos_valid: got %b want 0", bus.pos_valid); end
    checks++; if (bus.pos !== 2'd0) begin errors++; $display("FAIL reset_pos: got %0d want 0", bus.pos); end
    checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b want 0", bus.err_pulse); end
    checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", bus.err_count); end
    checks++; if (bus2.err_count !== 2'd0) begin errors++; $display("FAIL reset_sat_err_count: got %0d want 0", bus2.err_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock_sequence();
    vec_t t[5] = '{
      '{1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 8'd0},
      '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 8'd0},
      '{1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 8'd0},
      '{1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 8'd0},
      '{1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 8'd0}};
    foreach (t[i]) begin
      drive(t[i].v, t[i].r);
      checks++; if (bus.locked !== t[i].lk) begin errors++; $display("FAIL lock_seq[%0d] locked: got %b want %b", i, bus.locked, t[i].lk); end
      checks++; if (bus.pos_valid !== t[i].lk) begin errors++; $display("FAIL lock_seq[%0d] pos_valid: got %b want %b", i, bus.pos_valid, t[i].lk); end
      checks++; if (bus.pos !== t[i].p) begin errors++; $display("FAIL lock_seq[%0d] pos: got %0d want %0d", i, bus.pos, t[i].p); end
      checks++; if (bus.err_pulse !== t[i].ep) begin errors++; $display("FAIL lock_seq[%0d] err_pulse: got %b want %b", i, bus.err_pulse, t[i].ep); end
      checks++; if (bus.err_count !== t[i].ec) begin errors++; $display("FAIL lock_seq[%0d] err_count: got %0d want %0d", i, bus.err_count, t[i].ec); end
    end
  endtask

  task automatic test_seq_error();
    vec_t t[4] = '{
      '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 8'd0},
      '{1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 8'd0},
      '{1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 8'd1},
      '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 8'd1}};
    foreach (t[i]) begin
      drive(t[i].v, t[i].r);
      checks++; if (bus.locked !== t[i].lk) begin errors++; $display("FAIL seq_err[%0d] locked: got %b want %b", i, bus.locked, t[i].lk); end
      checks++; if (bus.pos !== t[i].p) begin errors++; $display("FAIL seq_err[%0d] pos: got %0d want %0d", i, bus.pos, t[i].p); end
      checks++; if (bus.err_pulse !== t[i].ep) begin errors++; $display("FAIL seq_err[%0d] err_pulse: got %b want %b", i, bus.err_pulse, t[i].ep); end
      checks++; if (bus.err_count !== t[i].ec) begin errors++; $display("FAIL seq_err[%0d] err_count: got %0d want %0d", i, bus.err_count, t[i].ec); end
    end
  endtask

  task automatic test_multihot();
    vec_t t[4] = '{
      '{1'b1, 4'b0110, 1'b0, 2'd3, 1'b1, 8'd2},
      '{1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 8'd2},
      '{1'b1, 4'b0100, 1'b0, 2'd2, 1'b0, 8'd2},
      '{1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 8'd2}};
    foreach (t[i]) begin
      drive(t[i].v, t[i].r);
      checks++; if (bus.locked !== t[i].lk) begin errors++; $display("FAIL multihot[%0d] locked: got %b want %b", i, bus.locked, t[i].lk); end
      checks++; if (bus.pos !== t[i].p) begin errors++; $display("FAIL multihot[%0d] pos: got %0d want %0d", i, bus.pos, t[i].p); end
      checks++; if (bus.err_pulse !== t[i].ep) begin errors++; $display("FAIL multihot[%0d] err_pulse: got %b want %b", i, bus.err_pulse, t[i].ep); end
      checks++; if (bus.err_count !== t[i].ec) begin errors++; $display("FAIL multihot[%0d] err_count: got %0d want %0d", i, bus.err_count, t[i].ec); end
    end
  endtask

  task automatic test_valid_gaps();
    vec_t t[6] = '{
      '{1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 8'd2},
      '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 8'd2},
      '{1'b0, 4'b1111, 1'b1, 2'd3, 1'b0, 8'd2},
      '{1'b0, 4'b0101, 1'b1, 2'd3, 1'b0, 8'd2},
      '{1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 8'd2},
      '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 8'd2}};
    foreach (t[i]) begin
      drive(t[i].v, t[i].r);
      checks++; if (bus.locked !== t[i].lk) begin errors++; $display("FAIL gaps[%0d] locked: got %b want %b", i, bus.locked, t[i].lk); end
      checks++; if (bus.pos !== t[i].p) begin errors++; $display("FAIL gaps[%0d] pos: got %0d want %0d", i, bus.pos, t[i].p); end
      checks++; if (bus.err_pulse !== t[i].ep) begin errors++; $display("FAIL gaps[%0d] err_pulse: got %b want %b", i, bus.err_pulse, t[i].ep); end
      checks++; if (bus.err_count !== t[i].ec) begin errors++; $display("FAIL gaps[%0d] err_count: got %0d want %0d", i, bus.err_count, t[i].ec); end
    end
  endtask

  task automatic test_stall();
    vec_t t[4] = '{
      '{1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 8'd3},
      '{1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 8'd3},
      '{1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 8'd3},
      '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 8'd3}};
    foreach (t[i]) begin
      drive(t[i].v, t[i].r);
      checks++; if (bus.locked !== t[i].lk) begin errors++; $display("FAIL stall[%0d] locked: got %b want %b", i, bus.locked, t[i].lk); end
      checks++; if (bus.pos !== t[i].p) begin errors++; $display("FAIL stall[%0d] pos: got %0d want %0d", i, bus.pos, t[i].p); end
      checks++; if (bus.err_pulse !== t[i].ep) begin errors++; $display("FAIL stall[%0d] err_pulse: got %b want %b", i, bus.err_pulse, t[i].ep); end
      checks++; if (bus.err_count !== t[i].ec) begin errors++; $display("FAIL stall[%0d] err_count: got %0d want %0d", i, bus.err_count, t[i].ec); end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_saturate();
    logic [3:0] cur;
    logic [1:0] want_cnt;
    drive2(1'b1, 4'b0001, 1'b0);
    drive2(1'b1, 4'b1000, 1'b0);
    checks++; if (bus2.locked !== 1'b1) begin errors++; $display("FAIL sat_initial_lock: got %b want 1", bus2.locked); end
    cur = 4'b1000;
    want_cnt = 2'd0;
    for (int k = 1; k <= 5; k++) begin
      if (want_cnt != 2'd3) want_cnt = want_cnt + 2'd1;
      drive2(1'b1, cur, 1'b0);
      checks++; if (bus2.err_pulse !== 1'b1) begin errors++; $display("FAIL sat_err_pulse[%0d]: got %b want 1", k, bus2.err_pulse); end
      checks++; if (bus2.err_count !== want_cnt) begin errors++; $display("FAIL sat_err_count[%0d]: got %0d want %0d", k, bus2.err_count, want_cnt); end
      cur = {cur[0], cur[3:1]};
      drive2(1'b1, cur, 1'b0);
      checks++; if (bus2.locked !== 1'b1) begin errors++; $display("FAIL sat_relock[%0d]: got %b want 1", k, bus2.locked); end
    end
    drive2(1'b1, cur, 1'b1);
    checks++; if (bus2.err_count !== 2'd0) begin errors++; $display("FAIL sat_clr_priority count: got %0d want 0", bus2.err_count); end
    checks++; if (bus2.err_pulse !== 1'b1) begin errors++; $display("FAIL sat_clr_priority pulse: got %b want 1", bus2.err_pulse); end
    cur = {cur[0], cur[3:1]};
    drive2(1'b1, cur, 1'b0);
    drive2(1'b1, cur, 1'b0);
    checks++; if (bus2.err_count !== 2'd1) begin errors++; $display("FAIL sat_after_clr count: got %0d want 1", bus2.err_count); end
    drive2(1'b0, 4'b0000, 1'b0);
  endtask

  task automatic test_async_reset();
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL areset_pre_locked: got %b want 1", bus.locked); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL areset_locked: got %b want 0", bus.locked); end
    checks++; if (bus.pos !== 2'd0) begin errors++; $display("FAIL areset_pos: got %0d want 0", bus.pos); end
    checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL areset_err_count: got %0d want 0", bus.err_count); end
    checks++; if (bus2.err_count !== 2'd0) begin errors++; $display("FAIL areset_sat_err_count: got %0d want 0", bus2.err_count); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 4'b0001);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL areset_relock1 locked: got %b want 0", bus.locked); end
    drive(1'b1, 4'b1000);
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL areset_relock2 locked: got %b want 1", bus.locked); end
    checks++; if (bus.pos !== 2'd3) begin errors++; $display("FAIL areset_relock2 pos: got %0d want 3", bus.pos); end
  endtask

  task automatic test_clr_err();
    drive(1'b1, 4'b1000);
    checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL clr_setup count: got %0d want 1", bus.err_count); end
    bus.clr_err = 1'b1;
    drive(1'b0, 4'b0000);
    bus.clr_err = 1'b0;
    checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", bus.err_count); end
    checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL clr_pulse: got %b want 0", bus.err_pulse); end
    checks++; if (bus.pos !== 2'd3) begin errors++; $display("FAIL clr_pos_hold: got %0d want 3", bus.pos); end
    drive(1'b1, 4'b0100);
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL clr_relock: got %b want 1", bus.locked); end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_seq_error();
    test_multihot();
    test_valid_gaps();
    test_stall();
    test_saturate();
    test_async_reset();
    test_clr_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
